// File: rtl/sound_pkg.sv
// sound_pkg -- definitions shared by the sound channels.
//   * Default register widths for the channel parameters.
//   * duty_t: the 2-bit duty-cycle selector.
//   * DUTY_TABLE: the four 8-step duty waveforms; bit n of an entry is the
//     output for duty step n.
//   * duty_bit(): looks up one waveform bit.
package sound_pkg;

  localparam int FREQ_W_DEFAULT = 11;
  localparam int LEN_W_DEFAULT  = 6;
  localparam int VOL_W_DEFAULT  = 4;
  localparam int ENV_W_DEFAULT  = 3;

  typedef logic [1:0] duty_t;

  // Written as steps 7..0 (MSB = step 7). Read from step 0 to step 7 they are:
  //   duty 0: 00000001   duty 1: 10000001   duty 2: 10000111   duty 3: 01111110
  localparam logic [3:0][7:0] DUTY_TABLE = {
    8'b0111_1110,   // duty 3
    8'b1110_0001,   // duty 2
    8'b1000_0001,   // duty 1
    8'b1000_0000    // duty 0
  };

  function automatic logic duty_bit(input duty_t duty, input logic [2:0] step);
    return DUTY_TABLE[duty][step];
  endfunction

endpackage

// File: rtl/sound_envelope.sv
// sound_envelope -- volume envelope shared by the pulse and noise channels.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   load             restart: vol <= initial_volume, timer <= period
//   tick             envelope step strobe (the caller gates it with its active state)
//   initial_volume   volume loaded on restart
//   increasing       step direction (1 = up)
//   period           ticks per volume step; 0 freezes the volume
//   vol              current volume
module sound_envelope
  import sound_pkg::*;
#(
  parameter int VOL_W = VOL_W_DEFAULT,
  parameter int ENV_W = ENV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             tick,
  input  logic [VOL_W-1:0] initial_volume,
  input  logic             increasing,
  input  logic [ENV_W-1:0] period,
  output logic [VOL_W-1:0] vol
);

  localparam logic [ENV_W-1:0] TIMER_ONE = {{(ENV_W-1){1'b0}}, 1'b1};
  localparam logic [VOL_W-1:0] VOL_ONE   = {{(VOL_W-1){1'b0}}, 1'b1};

  logic [ENV_W-1:0] timer_reg, timer_next;
  logic [VOL_W-1:0] vol_reg, vol_next;

  assign vol = vol_reg;

  always_comb begin
    timer_next = timer_reg;
    vol_next   = vol_reg;
    if (load) begin
      timer_next = period;
      vol_next   = initial_volume;
    end else if (tick && period != '0) begin
      // A timer at 1 (or left at 0 by an earlier period of 0) expires now.
      if (timer_reg <= TIMER_ONE) begin
        timer_next = period;
        if (increasing) begin
          if (vol_reg != '1) vol_next = vol_reg + VOL_ONE;
        end else begin
          if (vol_reg != '0) vol_next = vol_reg - VOL_ONE;
        end
      end else begin
        timer_next = timer_reg - TIMER_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_reg <= '0;
      vol_reg   <= '0;
    end else begin
      timer_reg <= timer_next;
      vol_reg   <= vol_next;
    end
  end

endmodule

// File: rtl/pulse_channel.sv
// pulse_channel -- square-wave sound channel: duty waveform, length counter,
// volume envelope and (optionally) frequency sweep.
// Build option: define PULSE_CHANNEL_SWEEP_EN to include the frequency sweep;
// without it the sweep_* inputs are ignored and frequency_data is followed
// continuously.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   freq_tick/len_tick/env_tick/sweep_tick   single-cycle step strobes
//   trigger                    restart the note
//   wave_duty                  duty waveform select
//   length_data, length_enable note length and its enable
//   initial_volume, envelope_increasing, envelope_period   envelope setup
//   sweep_period, sweep_decreasing, sweep_shift            sweep setup
//   frequency_data             period value (timer reload = 2^FREQ_W - value)
//   level                      registered output sample
//   active                     note is playing
module pulse_channel
  import sound_pkg::*;
#(
  parameter int FREQ_W = FREQ_W_DEFAULT,
  parameter int LEN_W  = LEN_W_DEFAULT,
  parameter int VOL_W  = VOL_W_DEFAULT,
  parameter int ENV_W  = ENV_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freq_tick,
  input  logic              len_tick,
  input  logic              env_tick,
  input  logic              sweep_tick,
  input  logic              trigger,
  input  duty_t             wave_duty,
  input  logic [LEN_W-1:0]  length_data,
  input  logic              length_enable,
  input  logic [VOL_W-1:0]  initial_volume,
  input  logic              envelope_increasing,
  input  logic [ENV_W-1:0]  envelope_period,
  input  logic [ENV_W-1:0]  sweep_period,
  input  logic              sweep_decreasing,
  input  logic [2:0]        sweep_shift,
  input  logic [FREQ_W-1:0] frequency_data,
  output logic [VOL_W-1:0]  level,
  output logic              active
);

  // Timers count up to 2^W, so they carry one extra bit.
  localparam logic [FREQ_W:0] FREQ_SPAN = {1'b1, {FREQ_W{1'b0}}};
  localparam logic [FREQ_W:0] FREQ_ONE  = {{FREQ_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0]  LEN_SPAN  = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0]  LEN_ONE   = {{LEN_W{1'b0}}, 1'b1};

  logic              active_reg, active_next;
  logic [VOL_W-1:0]  level_reg, level_next;
  logic [2:0]        duty_step_reg, duty_step_next;
  logic [FREQ_W:0]   freq_timer_reg, freq_timer_next;
  logic [LEN_W:0]    len_counter_reg, len_counter_next;
  logic [FREQ_W-1:0] shadow_reg, shadow_next;
  logic [VOL_W-1:0]  vol;
  logic              dac_on, load, run, len_expire, sweep_kill, trigger_kill;

  assign level  = level_reg;
  assign active = active_reg;

  // With the DAC off a trigger cannot start a note. Ticks only act on a note
  // that is already playing and are pre-empted by a trigger.
  assign dac_on = (initial_volume != '0) || envelope_increasing;
  assign load   = trigger && dac_on;
  assign run    = active_reg && !load;

  sound_envelope #(
    .VOL_W (VOL_W),
    .ENV_W (ENV_W)
  ) u_envelope (
    .clk            (clk),
    .reset          (reset),
    .load           (load),
    .tick           (env_tick && run),
    .initial_volume (initial_volume),
    .increasing     (envelope_increasing),
    .period         (envelope_period),
    .vol            (vol)
  );

  // Frequency timer and duty step.
  always_comb begin
    freq_timer_next = freq_timer_reg;
    duty_step_next  = duty_step_reg;
    if (load) begin
      freq_timer_next = FREQ_SPAN - {1'b0, frequency_data};
      duty_step_next  = '0;
    end else if (run && freq_tick) begin
      if (freq_timer_reg <= FREQ_ONE) begin
        freq_timer_next = FREQ_SPAN - {1'b0, shadow_reg};
        duty_step_next  = duty_step_reg + 3'd1;
      end else begin
        freq_timer_next = freq_timer_reg - FREQ_ONE;
      end
    end
  end

  // The length counter keeps counting even when the note is silent.
  always_comb begin
    len_counter_next = len_counter_reg;
    len_expire       = 1'b0;
    if (load) begin
      len_counter_next = LEN_SPAN - {1'b0, length_data};
    end else if (len_tick && length_enable && len_counter_reg != '0) begin
      len_counter_next = len_counter_reg - LEN_ONE;
      len_expire       = (len_counter_reg == LEN_ONE);
    end
  end

`ifdef PULSE_CHANNEL_SWEEP_EN
  localparam logic [ENV_W:0] SWEEP_ONE = {{ENV_W{1'b0}}, 1'b1};

  logic [ENV_W:0]  sweep_timer_reg, sweep_timer_next, sweep_reload;
  logic [FREQ_W:0] sweep_sum, trigger_sum;

  // One extra bit so an overflow shows up in bit FREQ_W instead of wrapping.
  function automatic logic [FREQ_W:0] sweep_calc(input logic [FREQ_W-1:0] base,
                                                  input logic [2:0] shift,
                                                  input logic decreasing);
    logic [FREQ_W:0] wide;
    logic [FREQ_W:0] delta;
    wide  = {1'b0, base};
    delta = wide >> shift;
    return decreasing ? (wide - delta) : (wide + delta);
  endfunction

  assign sweep_sum    = sweep_calc(shadow_reg, sweep_shift, sweep_decreasing);
  assign trigger_sum  = sweep_calc(frequency_data, sweep_shift, sweep_decreasing);
  assign trigger_kill = (sweep_shift != 3'd0) && trigger_sum[FREQ_W];
  // A sweep period of 0 still paces the timer, as 2^ENV_W ticks.
  assign sweep_reload = (sweep_period == '0) ? {1'b1, {ENV_W{1'b0}}} : {1'b0, sweep_period};

  always_comb begin
    sweep_timer_next = sweep_timer_reg;
    shadow_next      = shadow_reg;
    sweep_kill       = 1'b0;
    if (load) begin
      sweep_timer_next = sweep_reload;
      shadow_next      = frequency_data;
    end else if (run && sweep_tick) begin
      if (sweep_timer_reg <= SWEEP_ONE) begin
        sweep_timer_next = sweep_reload;
        if (sweep_period != '0) begin
          if (sweep_sum[FREQ_W]) sweep_kill = 1'b1;
          else if (sweep_shift != 3'd0) shadow_next = sweep_sum[FREQ_W-1:0];
        end
      end else begin
        sweep_timer_next = sweep_timer_reg - SWEEP_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) sweep_timer_reg <= '0;
    else       sweep_timer_reg <= sweep_timer_next;
  end
`else
  // No sweep: the shadow simply follows frequency_data.
  logic unused_sweep;
  assign unused_sweep = ^{sweep_tick, sweep_period, sweep_decreasing, sweep_shift};
  assign shadow_next  = frequency_data;
  assign trigger_kill = 1'b0;
  assign sweep_kill   = 1'b0;
`endif

  always_comb begin
    active_next = active_reg;
    if (!dac_on)                       active_next = 1'b0;
    else if (load)                     active_next = !trigger_kill;
    else if (len_expire || sweep_kill) active_next = 1'b0;
  end

  // Level is computed from the current step, so it follows a step change one clock later.
  assign level_next = (active_reg && duty_bit(wave_duty, duty_step_reg)) ? vol : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_reg      <= 1'b0;
      level_reg       <= '0;
      duty_step_reg   <= '0;
      freq_timer_reg  <= '0;
      len_counter_reg <= '0;
      shadow_reg      <= '0;
    end else begin
      active_reg      <= active_next;
      level_reg       <= level_next;
      duty_step_reg   <= duty_step_next;
      freq_timer_reg  <= freq_timer_next;
      len_counter_reg <= len_counter_next;
      shadow_reg      <= shadow_next;
    end
  end

endmodule

// File: tb/tb_pulse_channel.sv
// tb_pulse_channel -- self-checking bench for pulse_channel: a table of
// directed vectors, hand-written multi-cycle sequences, then randomized
// stimulus compared against a behavioural model of the channel.
module tb_pulse_channel;

  localparam int FW   = 11;
  localparam int LW   = 6;
  localparam int VW   = 4;
  localparam int EW   = 3;
  localparam int VMAX = (1 << VW) - 1;

  logic          clk = 1'b0;
  logic          reset, freq_tick, len_tick, env_tick, sweep_tick, trigger;
  logic [1:0]    wave_duty;
  logic [LW-1:0] length_data;
  logic          length_enable;
  logic [VW-1:0] initial_volume;
  logic          envelope_increasing;
  logic [EW-1:0] envelope_period, sweep_period;
  logic          sweep_decreasing;
  logic [2:0]    sweep_shift;
  logic [FW-1:0] frequency_data;
  logic [VW-1:0] level;
  logic          active;

  always #5 clk = ~clk;

  pulse_channel #(.FREQ_W(FW), .LEN_W(LW), .VOL_W(VW), .ENV_W(EW)) dut (
    .clk(clk), .reset(reset), .freq_tick(freq_tick), .len_tick(len_tick),
    .env_tick(env_tick), .sweep_tick(sweep_tick), .trigger(trigger),
    .wave_duty(wave_duty), .length_data(length_data), .length_enable(length_enable),
    .initial_volume(initial_volume), .envelope_increasing(envelope_increasing),
    .envelope_period(envelope_period), .sweep_period(sweep_period),
    .sweep_decreasing(sweep_decreasing), .sweep_shift(sweep_shift),
    .frequency_data(frequency_data), .level(level), .active(active)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_strobes();
    reset = 0; trigger = 0; freq_tick = 0; len_tick = 0; env_tick = 0; sweep_tick = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst, trig, ft, lt, et;
    bit [1:0] duty;
    int iv; bit inc; int ep; int ld; bit le; int fd;
    bit ea; int el;
  } vec_t;

  vec_t vecs[$];
  bit [1:0] c_duty; int c_iv; bit c_inc; int c_ep; int c_ld; bit c_le; int c_fd;

  task automatic row(input bit rst, trig, ft, lt, et, ea, input int el);
    vec_t v;
    v.rst = rst; v.trig = trig; v.ft = ft; v.lt = lt; v.et = et;
    v.duty = c_duty; v.iv = c_iv; v.inc = c_inc; v.ep = c_ep; v.ld = c_ld;
    v.le = c_le; v.fd = c_fd; v.ea = ea; v.el = el;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; trigger = v.trig; freq_tick = v.ft; len_tick = v.lt; env_tick = v.et;
    sweep_tick = 0;
    wave_duty = v.duty; initial_volume = v.iv[VW-1:0]; envelope_increasing = v.inc;
    envelope_period = v.ep[EW-1:0]; length_data = v.ld[LW-1:0]; length_enable = v.le;
    frequency_data = v.fd[FW-1:0];
  endtask

  // ---------------- behavioural model ----------------
  string pat [4] = '{"00000001", "10000001", "10000111", "01111110"};
  int m_active, m_vol, m_step, m_ft, m_len, m_env, m_shadow, m_level;

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_edge();
    bit dac, load, run;
    int nl;
    string p;
    if (reset) begin
      m_active = 0; m_vol = 0; m_step = 0; m_ft = 0; m_len = 0; m_env = 0;
      m_shadow = 0; m_level = 0;
      return;
    end
    p  = pat[wave_duty];
    nl = (m_active != 0 && p[m_step] == "1") ? m_vol : 0;
    dac  = (initial_volume != 0) || envelope_increasing;
    load = trigger && dac;
    run  = (m_active != 0) && !load;
    if (load) begin
      m_active = 1; m_step = 0; m_vol = initial_volume; m_env = envelope_period;
      m_len = (1 << LW) - int'(length_data);
      m_ft  = (1 << FW) - int'(frequency_data);
    end else begin
      if (run && freq_tick) begin
        if (m_ft <= 1) begin
          m_ft = (1 << FW) - m_shadow;
          m_step = (m_step + 1) % 8;
        end else m_ft--;
      end
      if (run && env_tick && envelope_period != 0) begin
        if (m_env <= 1) begin
          m_env = envelope_period;
          if (envelope_increasing) m_vol = (m_vol < VMAX) ? m_vol + 1 : VMAX;
          else                     m_vol = (m_vol > 0) ? m_vol - 1 : 0;
        end else m_env--;
      end
      if (len_tick && length_enable && m_len != 0) begin
        m_len--;
        if (m_len == 0) m_active = 0;
      end
    end
    if (!dac) m_active = 0;
`ifdef PULSE_CHANNEL_SWEEP_EN
    if (load) m_shadow = frequency_data;
`else
    m_shadow = frequency_data;
`endif
    m_level = nl;
  endtask

  int duty2_lv [10] = '{15, 0, 0, 0, 0, 15, 15, 15, 15, 0};

  initial begin
    idle_strobes();
    reset = 1; wave_duty = 0; length_data = 0; length_enable = 0; initial_volume = 0;
    envelope_increasing = 0; envelope_period = 0; sweep_period = 0; sweep_decreasing = 0;
    sweep_shift = 0; frequency_data = 0;

    // Duty 2 at the fastest frequency: one step per freq_tick.
    c_duty = 2; c_iv = 15; c_inc = 0; c_ep = 0; c_ld = 0; c_le = 0; c_fd = 2047;
    row(1, 0, 0, 0, 0, 0, 0);
    row(0, 1, 1, 0, 0, 1, 0);          // trigger wins over the freq_tick
    for (int i = 0; i < 10; i++) row(0, 0, 1, 0, 0, 1, duty2_lv[i]);
    // Length 62 expires after two len_ticks.
    c_duty = 1; c_ld = 62; c_le = 1;
    row(1, 0, 0, 0, 0, 0, 0);
    row(0, 1, 0, 0, 0, 1, 0);
    row(0, 0, 0, 1, 0, 1, 15);
    row(0, 0, 0, 1, 0, 0, 15);
    row(0, 0, 0, 0, 0, 0, 0);
    // Envelope decreasing from 2 with period 1.
    c_iv = 2; c_ep = 1; c_le = 0;
    row(1, 0, 0, 0, 0, 0, 0);
    row(0, 1, 0, 0, 0, 1, 0);
    row(0, 0, 0, 0, 1, 1, 2);
    row(0, 0, 0, 0, 1, 1, 1);
    row(0, 0, 0, 0, 1, 1, 0);
    row(0, 0, 0, 0, 0, 1, 0);
    // Envelope increasing from 15 stays at 15.
    c_iv = 15; c_inc = 1;
    row(1, 0, 0, 0, 0, 0, 0);
    row(0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) row(0, 0, 0, 0, 1, 1, 15);
    row(0, 0, 0, 0, 0, 1, 15);
    // Envelope increasing from 14 saturates at 15.
    c_iv = 14;
    row(1, 0, 0, 0, 0, 0, 0);
    row(0, 1, 0, 0, 0, 1, 0);
    row(0, 0, 0, 0, 1, 1, 14);
    row(0, 0, 0, 0, 1, 1, 15);
    row(0, 0, 0, 0, 1, 1, 15);
    // DAC off: trigger does not start a note.
    c_iv = 0; c_inc = 0; c_ep = 0;
    row(1, 0, 0, 0, 0, 0, 0);
    row(0, 1, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0);
    // DAC switched off mid-note stops the note on the next clock.
    c_iv = 9;
    row(1, 0, 0, 0, 0, 0, 0);
    row(0, 1, 0, 0, 0, 1, 0);
    row(0, 0, 0, 0, 0, 1, 9);
    c_iv = 0;
    row(0, 0, 0, 0, 0, 0, 9);
    row(0, 0, 0, 0, 0, 0, 0);
    // Reset together with trigger mid-note.
    c_iv = 15;
    row(1, 0, 0, 0, 0, 0, 0);
    row(0, 1, 0, 0, 0, 1, 0);
    row(0, 0, 0, 0, 0, 1, 15);
    row(1, 1, 1, 1, 1, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      cyc();
      check($sformatf("row%0d_active", i), active, vecs[i].ea);
      check($sformatf("row%0d_level", i), level, vecs[i].el);
      $display("row %0d active %0d level %0d", i, active, level);
    end

    // Length disabled: counter holds through 100 len_ticks, then resumes.
    idle_strobes(); reset = 1; cyc(); reset = 0;
    wave_duty = 1; initial_volume = 15; envelope_increasing = 0; envelope_period = 0;
    length_data = 62; length_enable = 0; frequency_data = 2047;
    trigger = 1; cyc(); trigger = 0;
    len_tick = 1;
    repeat (100) cyc();
    len_tick = 0; cyc();
    check("len_hold_active", active, 1);
    check("len_hold_level", level, 15);
    length_enable = 1; len_tick = 1;
    cyc(); check("len_resume_first", active, 1);
    cyc(); check("len_resume_expire", active, 0);
    len_tick = 0; cyc(); check("len_resume_level", level, 0);
    $display("length hold sequence active %0d level %0d", active, level);

`ifdef PULSE_CHANNEL_SWEEP_EN
    // 1500 + 750 > 2047: the note dies in the trigger cycle.
    idle_strobes(); reset = 1; cyc(); reset = 0;
    frequency_data = 1500; sweep_shift = 1; sweep_decreasing = 0; sweep_period = 0;
    initial_volume = 15;
    trigger = 1; cyc(); trigger = 0;
    check("sweep_trigger_overflow", active, 0);
    sweep_decreasing = 1;
    trigger = 1; cyc(); trigger = 0;
    check("sweep_trigger_decrease", active, 1);
    $display("sweep trigger sequence active %0d", active);
    sweep_shift = 0; sweep_decreasing = 0;
`endif

    // Randomized run against the model.
    idle_strobes();
    sweep_shift = 0; sweep_period = 0; sweep_decreasing = 0;
    for (int n = 0; n < 3000; n++) begin
      reset      = (n == 0) || ($urandom_range(0, 299) == 0);
      trigger    = ($urandom_range(0, 24) == 0);
      freq_tick  = 1'($urandom_range(0, 1));
      len_tick   = ($urandom_range(0, 5) == 0);
      env_tick   = ($urandom_range(0, 5) == 0);
      sweep_tick = 0;
      if (n == 0 || $urandom_range(0, 19) == 0) begin
        wave_duty           = 2'($urandom_range(0, 3));
        initial_volume      = ($urandom_range(0, 3) == 0) ? '0 : VW'($urandom_range(0, VMAX));
        envelope_increasing = 1'($urandom_range(0, 1));
        envelope_period     = EW'($urandom_range(0, 7));
        length_data         = LW'($urandom_range(40, 63));
        length_enable       = 1'($urandom_range(0, 1));
        frequency_data      = ($urandom_range(0, 1) == 1) ? FW'($urandom_range(2040, 2047))
                                                          : FW'($urandom_range(0, 2047));
      end
      model_edge();
      cyc();
      check($sformatf("rand%0d_active", n), active, m_active);
      check($sformatf("rand%0d_level", n), level, m_level);
    end
    $display("random run complete cycles %0d", 3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
